// File: rtl/reg_write_arbiter.sv
// Two-source writeback arbiter for the 8088 register bank. A has priority, and B is protected from starvation.
// Optional read bypass of the pending write is enabled with `define WB_BYPASS_EN.
module reg_write_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [7:0]        busy_mask,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
);

  localparam logic [0:0] PRI_A = 1'b0;
  localparam logic [0:0] PRI_B = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [0:0] state, state_nxt;
  logic [3:0] starve_cnt, cnt_nxt;
  logic       grant_a, grant_b;
  logic       wr_vld_q;

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    if (reset) begin
      case (state)
        PRI_B: begin
          // B keeps its turn only while it is still asking; either way we return to A priority.
          grant_b   = b_valid;
          grant_a   = !b_valid && a_valid;
          cnt_nxt   = 4'd0;
          state_nxt = PRI_A;
        end
        default: begin
          grant_a = a_valid;
          grant_b = !a_valid && b_valid;
          if (grant_a && b_valid) begin
            cnt_nxt = (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
            if (cnt_nxt == STARVE_LIM) state_nxt = PRI_B;
          end else begin
            cnt_nxt = 4'd0;
          end
        end
      endcase
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // NOTE: sequential state uses non-blocking assignments only, so all registers sample the pre-edge values together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= PRI_A;
      starve_cnt <= 4'd0;
      wr_vld_q   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      wr_vld_q   <= grant_a || grant_b;
      if (grant_a) begin
        rf_wr_reg  <= a_reg;
        rf_wr_data <= a_data;
      end else if (grant_b) begin
        rf_wr_reg  <= b_reg;
        rf_wr_data <= b_data;
      end
    end
  end

  // Gating with reset drops a write that is still in the stage when reset is asserted.
  assign rf_wr_en = wr_vld_q && reset;

  always_comb begin
    busy_mask = 8'h00;
    if (rf_wr_en) busy_mask[rf_wr_reg] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign byp_data1 = (rf_wr_en && rf_wr_reg == rd_reg1) ? rf_wr_data : rf_data1;
  assign byp_data2 = (rf_wr_en && rf_wr_reg == rd_reg2) ? rf_wr_data : rf_data2;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_reg1, rd_reg2};
  assign byp_data1 = rf_data1;
  assign byp_data2 = rf_data2;
`endif

endmodule
